scan_seq_3b: RTL and testbench

- Upstream index generator for the 3-to-8 decoder stage.
- Produces a 3-bit select index that steps through 0..7 at a programmable rate, for multiplexing 8 LEDs, display digits or keypad rows.
- Supports up, down, ping-pong and hold modes, a single-step request while disabled, and a one-cycle wrap/turn pulse.
- The decoder consumes `sel` directly.

---
 rtl/scan_seq_3b.sv | 145 ++++++++++++++
 tb/tb_scan_seq_3b.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_seq_3b.sv
// 3-bit scan index generator for a 3-to-8 decoder: programmable-rate up/down/ping-pong/hold stepping.
// Define SCAN_SEQ_BLANK_EN to add the `blank` output used to suppress ghosting between indices.
module scan_seq_3b #(
    parameter int             DIV_W     = 16,
    parameter logic [2:0]     SEL_INIT  = 3'd0,
    parameter int             BLANK_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       mode,
    input  logic             step,
    output logic [2:0]       sel,
    output logic             tick,
    output logic             wrap
`ifdef SCAN_SEQ_BLANK_EN
    ,
    output logic             blank
`endif
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_PING = 2'b10,
        MODE_HOLD = 2'b11
    } mode_t;

    if (BLANK_CYC < 1) begin : g_bad_blank_cyc
        $error("scan_seq_3b: BLANK_CYC must be at least 1");
    end

    dir_t             dir;
    dir_t             nxt_dir;
    logic             step_q;
    logic             step_rise;
    logic             adv;
    logic [DIV_W-1:0] cnt;
    logic [2:0]       nxt_sel;
    logic             nxt_wrap;

`ifdef SCAN_SEQ_BLANK_EN
    logic [DIV_W-1:0] bcnt;
`endif

    // A step edge only counts while auto-advance is disabled.
    always_comb begin
        step_rise = step & ~step_q;
        adv       = en ? (cnt >= div) : step_rise;
        nxt_sel   = sel;
        nxt_wrap  = 1'b0;
        nxt_dir   = dir;
        case (mode_t'(mode))
            MODE_UP: begin
                nxt_sel  = sel + 3'd1;
                nxt_wrap = (sel == 3'd7);
            end
            MODE_DOWN: begin
                nxt_sel  = sel - 3'd1;
                nxt_wrap = (sel == 3'd0);
            end
            MODE_PING: begin
                if (dir == DIR_UP) begin
                    if (sel == 3'd7) begin
                        nxt_sel  = 3'd6;
                        nxt_wrap = 1'b1;
                        nxt_dir  = DIR_DOWN;
                    end else begin
                        nxt_sel = sel + 3'd1;
                    end
                end else begin
                    if (sel == 3'd0) begin
                        nxt_sel  = 3'd1;
                        nxt_wrap = 1'b1;
                        nxt_dir  = DIR_UP;
                    end else begin
                        nxt_sel = sel - 3'd1;
                    end
                end
            end
            default: begin
                nxt_sel  = sel;
                nxt_wrap = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel    <= SEL_INIT;
            cnt    <= '0;
            tick   <= 1'b0;
            wrap   <= 1'b0;
            dir    <= DIR_UP;
            step_q <= 1'b0;
`ifdef SCAN_SEQ_BLANK_EN
            blank  <= 1'b0;
            bcnt   <= '0;
`endif
        end else begin
            step_q <= step;

            // Compare with >= so a shrinking div fires immediately instead of wrapping the counter.
            if (en) begin
                cnt <= (cnt >= div) ? '0 : cnt + DIV_W'(1);
            end else if (step_rise) begin
                cnt <= '0;
            end

            tick <= adv;
            wrap <= adv & nxt_wrap;
            if (adv) begin
                sel <= nxt_sel;
            end

            // Up/down pin the direction continuously so ping-pong resumes the way it was last going.
            case (mode_t'(mode))
                MODE_UP:   dir <= DIR_UP;
                MODE_DOWN: dir <= DIR_DOWN;
                MODE_PING: if (adv) dir <= nxt_dir;
                default:   dir <= dir;
            endcase

`ifdef SCAN_SEQ_BLANK_EN
            if (adv) begin
                blank <= 1'b1;
                bcnt  <= DIV_W'(BLANK_CYC - 1);
            end else if (blank) begin
                if (bcnt == '0) begin
                    blank <= 1'b0;
                end else begin
                    bcnt <= bcnt - DIV_W'(1);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_scan_seq_3b.sv
// Directed self-checking bench for scan_seq_3b; also checks `blank` when SCAN_SEQ_BLANK_EN is defined.
module tb_scan_seq_3b;

    localparam int DIV_W = 16;

    localparam logic [2:0] PP_SEL [15] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                                           3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
    localparam logic [2:0] DN_SEL [5]  = '{3'd1, 3'd0, 3'd7, 3'd6, 3'd5};

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [DIV_W-1:0] div;
    logic [1:0]       mode;
    logic             step;
    logic [2:0]       sel;
    logic             tick;
    logic             wrap;
`ifdef SCAN_SEQ_BLANK_EN
    logic             blank;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    scan_seq_3b #(
        .DIV_W     (DIV_W),
        .SEL_INIT  (3'd0),
        .BLANK_CYC (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .div   (div),
        .mode  (mode),
        .step  (step),
        .sel   (sel),
        .tick  (tick),
        .wrap  (wrap)
`ifdef SCAN_SEQ_BLANK_EN
        ,
        .blank (blank)
`endif
    );

    task automatic applyStimulus(input logic r, input logic e, input logic [DIV_W-1:0] d,
                                 input logic [1:0] m, input logic s);
        rst  = r;
        en   = e;
        div  = d;
        mode = m;
        step = s;
    endtask

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic nextCycle;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] es, input logic et, input logic ew);
        checks++;
        assert (sel === es) else begin
            failures++;
            $error("[TB] FAIL %s sel: got %0d expected %0d", tag, sel, es);
        end
        checks++;
        assert (tick === et) else begin
            failures++;
            $error("[TB] FAIL %s tick: got %b expected %b", tag, tick, et);
        end
        checks++;
        assert (wrap === ew) else begin
            failures++;
            $error("[TB] FAIL %s wrap: got %b expected %b", tag, wrap, ew);
        end
    endtask

    task automatic checkBlank(input string tag, input logic eb);
`ifdef SCAN_SEQ_BLANK_EN
        checks++;
        assert (blank === eb) else begin
            failures++;
            $error("[TB] FAIL %s blank: got %b expected %b", tag, blank, eb);
        end
`else
        if (eb === 1'bx) $display("[TB] %s", tag);
`endif
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 16'd0, 2'b00, 1'b0);
        nextCycle;
        nextCycle;
        checkOutput("reset", 3'd0, 1'b0, 1'b0);
        checkBlank("reset", 1'b0);

        // Up run, div=3: a tick every 4th clock, first one 4 clocks after reset release.
        applyStimulus(1'b0, 1'b1, 16'd3, 2'b00, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            for (int j = 1; j <= 4; j++) begin
                nextCycle;
                if (j < 4) checkOutput("up_idle", 3'(i - 1), 1'b0, 1'b0);
                else       checkOutput("up_tick", 3'(i % 8), 1'b1, (i == 8));
                checkBlank("up_blank", (j == 4) || (j == 1 && i > 1));
            end
        end

        // Ping-pong at div=0 from sel=0, dir=UP.
        applyStimulus(1'b0, 1'b1, 16'd0, 2'b10, 1'b0);
        for (int k = 0; k < 15; k++) begin
            nextCycle;
            checkOutput("pingpong", PP_SEL[k], 1'b1, (k == 7) || (k == 14));
            checkBlank("pp_blank", 1'b1);
        end
        nextCycle;
        checkOutput("pp_to2", 3'd2, 1'b1, 1'b0);

        // Down from 2, then switch to ping-pong at 5 keeping the downward direction.
        applyStimulus(1'b0, 1'b1, 16'd0, 2'b01, 1'b0);
        for (int k = 0; k < 5; k++) begin
            nextCycle;
            checkOutput("down", DN_SEL[k], 1'b1, (k == 2));
        end
        applyStimulus(1'b0, 1'b1, 16'd0, 2'b10, 1'b0);
        nextCycle;
        checkOutput("pp_keepdir4", 3'd4, 1'b1, 1'b0);
        nextCycle;
        checkOutput("pp_keepdir3", 3'd3, 1'b1, 1'b0);

        // Hold still pulses tick without moving sel.
        applyStimulus(1'b0, 1'b1, 16'd0, 2'b11, 1'b0);
        for (int k = 0; k < 3; k++) begin
            nextCycle;
            checkOutput("hold", 3'd3, 1'b1, 1'b0);
        end

        // Count to 4 with div=9, freeze, then single-step with step held high.
        applyStimulus(1'b0, 1'b1, 16'd9, 2'b00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            nextCycle;
            checkOutput("pre_freeze", 3'd3, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 16'd9, 2'b00, 1'b0);
        for (int k = 0; k < 8; k++) begin
            nextCycle;
            checkOutput("frozen", 3'd3, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 16'd9, 2'b00, 1'b1);
        nextCycle;
        checkOutput("step_tick", 3'd4, 1'b1, 1'b0);
        checkBlank("step_blank", 1'b1);
        for (int k = 0; k < 4; k++) begin
            nextCycle;
            checkOutput("step_held", 3'd4, 1'b0, 1'b0);
            checkBlank("step_held_blank", (k == 0));
        end
        applyStimulus(1'b0, 1'b1, 16'd9, 2'b00, 1'b0);
        for (int k = 0; k < 9; k++) begin
            nextCycle;
            checkOutput("resume_idle", 3'd4, 1'b0, 1'b0);
        end
        nextCycle;
        checkOutput("resume_tick", 3'd5, 1'b1, 1'b0);

        // div=20 count to 12 (a step pulse with en=1 is ignored), then shrink div to 5.
        applyStimulus(1'b0, 1'b1, 16'd20, 2'b00, 1'b0);
        for (int k = 0; k < 12; k++) begin
            if (k == 3)      applyStimulus(1'b0, 1'b1, 16'd20, 2'b00, 1'b1);
            else if (k == 4) applyStimulus(1'b0, 1'b1, 16'd20, 2'b00, 1'b0);
            nextCycle;
            checkOutput("div20_idle", 3'd5, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 16'd5, 2'b00, 1'b0);
        nextCycle;
        checkOutput("div_shrink", 3'd6, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            nextCycle;
            checkOutput("div5_idle", 3'd6, 1'b0, 1'b0);
        end

        // Reset lands exactly where an advance was due; it must win and discard the count.
        applyStimulus(1'b1, 1'b1, 16'd5, 2'b00, 1'b0);
        nextCycle;
        checkOutput("rst_mid", 3'd0, 1'b0, 1'b0);
        checkBlank("rst_mid_blank", 1'b0);
        applyStimulus(1'b0, 1'b1, 16'd5, 2'b00, 1'b0);
        for (int k = 0; k < 5; k++) begin
            nextCycle;
            checkOutput("post_rst_idle", 3'd0, 1'b0, 1'b0);
        end
        nextCycle;
        checkOutput("post_rst_tick", 3'd1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
